// File: rtl/ifft_reorder_buf.sv
// Ping-pong frame reorder buffer: scattered IFFT output in, natural-order valid/ready frames out.
// Define IFFT_REORDER_OVF_EN to add the sticky ovf output port.
module ifft_reorder_buf #(
   parameter int unsigned TOTAL_STAGE_P = 10,
   parameter int unsigned MULT_WIDTH_P  = 18
) (
   input  logic                     iclk,
   input  logic                     rst,
   input  logic                     ien,
   input  logic [TOTAL_STAGE_P-1:0] iaddr,
   input  logic [MULT_WIDTH_P-1:0]  iReal,
   input  logic [MULT_WIDTH_P-1:0]  iImag,
   output logic                     oValid,
   input  logic                     iReady,
   output logic [TOTAL_STAGE_P-1:0] oaddr,
   output logic [MULT_WIDTH_P-1:0]  oReal,
   output logic [MULT_WIDTH_P-1:0]  oImag,
   output logic                     olast
`ifdef IFFT_REORDER_OVF_EN
   ,
   output logic                     ovf
`endif
);

   localparam int unsigned AW = TOTAL_STAGE_P;
   localparam int unsigned MW = MULT_WIDTH_P;
   localparam int unsigned DW = 2 * MW;
   localparam int unsigned N  = 1 << AW;
   localparam logic [AW:0] CNT_LAST = (AW+1)'(N - 1);

   typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_e;
   typedef enum logic {S_IDLE, S_STREAM} rd_st_e;
   typedef struct packed {
      logic          last;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } beat_t;

   logic [DW-1:0] mem_q [0:2*N-1];
   logic [DW-1:0] rdata_q;

   bank_st_e      bank_q [2];
   bank_st_e      bank_d [2];
   logic          wr_bank_q, wr_bank_d;
   logic [AW:0]   wr_cnt_q, wr_cnt_d;
   bank_st_e      wr_st;
   logic          wr_acc, wr_frame_done;

   rd_st_e        rd_st_q, rd_st_d;
   logic          rd_bank_q, rd_bank_d;
   logic [AW-1:0] rd_idx_q, rd_idx_d;
   logic          issue, issue_first, release_bank;
   logic [AW-1:0] issue_addr;

   logic          infl_q, infl_last_q;
   logic [AW-1:0] infl_addr_q;
   beat_t         skid_q [2];
   beat_t         head;
   logic          skid_rd_q, skid_wr_q;
   logic [1:0]    skid_cnt_q, occ;
   logic          pop, can_issue;

   assign oValid    = (skid_cnt_q != 2'd0);
   assign pop       = oValid & iReady;
   assign occ       = skid_cnt_q + {1'b0, infl_q};
   // Skid slots plus the in-flight RAM read never exceed two entries.
   assign can_issue = (occ < 2'd2) || ((occ == 2'd2) && pop);

   always_comb begin
      rd_st_d      = rd_st_q;
      rd_bank_d    = rd_bank_q;
      rd_idx_d     = rd_idx_q;
      issue        = 1'b0;
      issue_first  = 1'b0;
      release_bank = 1'b0;
      issue_addr   = rd_idx_q;
      case (rd_st_q)
         S_IDLE: begin
            issue_addr = '0;
            if ((bank_q[rd_bank_q] == B_FULL) && can_issue) begin
               issue       = 1'b1;
               issue_first = 1'b1;
               rd_idx_d    = AW'(1);
               rd_st_d     = S_STREAM;
            end
         end
         S_STREAM: begin
            if (can_issue) begin
               issue    = 1'b1;
               rd_idx_d = rd_idx_q + 1'b1;
               // Bank is free once its last word has left the RAM; the tail beats live in the skid.
               if (rd_idx_q == '1) begin
                  release_bank = 1'b1;
                  rd_bank_d    = ~rd_bank_q;
                  rd_st_d      = S_IDLE;
               end
            end
         end
      endcase
   end

   always_comb begin
      wr_st         = (release_bank && (rd_bank_q == wr_bank_q)) ? B_EMPTY : bank_q[wr_bank_q];
      wr_acc        = ien && ((wr_st == B_EMPTY) || (wr_st == B_FILLING));
      wr_frame_done = wr_acc && (wr_cnt_q == CNT_LAST);
      wr_cnt_d      = wr_cnt_q;
      wr_bank_d     = wr_bank_q;
      if (wr_acc) begin
         if (wr_frame_done) begin
            wr_cnt_d  = '0;
            wr_bank_d = ~wr_bank_q;
         end else begin
            wr_cnt_d  = wr_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      bank_d = bank_q;
      if (issue_first)  bank_d[rd_bank_q] = B_DRAINING;
      if (release_bank) bank_d[rd_bank_q] = B_EMPTY;
      if (wr_acc)       bank_d[wr_bank_q] = wr_frame_done ? B_FULL : B_FILLING;
   end

   always_ff @(posedge iclk) begin
      if (wr_acc) mem_q[{wr_bank_q, iaddr}] <= {iReal, iImag};
      if (issue)  rdata_q <= mem_q[{rd_bank_q, issue_addr}];
   end

   always_ff @(posedge iclk) begin
      if (rst) begin
         bank_q      <= '{default: B_EMPTY};
         wr_bank_q   <= 1'b0;
         wr_cnt_q    <= '0;
         rd_st_q     <= S_IDLE;
         rd_bank_q   <= 1'b0;
         rd_idx_q    <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         infl_addr_q <= '0;
      end else begin
         bank_q      <= bank_d;
         wr_bank_q   <= wr_bank_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_st_q     <= rd_st_d;
         rd_bank_q   <= rd_bank_d;
         rd_idx_q    <= rd_idx_d;
         infl_q      <= issue;
         infl_last_q <= (issue_addr == '1);
         infl_addr_q <= issue_addr;
      end
   end

   always_ff @(posedge iclk) begin
      if (rst) begin
         skid_q     <= '{default: '0};
         skid_rd_q  <= 1'b0;
         skid_wr_q  <= 1'b0;
         skid_cnt_q <= 2'd0;
      end else begin
         if (infl_q) begin
            skid_q[skid_wr_q] <= {infl_last_q, infl_addr_q, rdata_q};
            skid_wr_q         <= ~skid_wr_q;
         end
         if (pop) skid_rd_q <= ~skid_rd_q;
         skid_cnt_q <= skid_cnt_q + {1'b0, infl_q} - {1'b0, pop};
      end
   end

   assign head  = skid_q[skid_rd_q];
   assign oaddr = head.addr;
   assign oReal = head.data[DW-1:MW];
   assign oImag = head.data[MW-1:0];
   assign olast = head.last;

`ifdef IFFT_REORDER_OVF_EN
   logic ovf_q;
   always_ff @(posedge iclk) begin
      if (rst)                  ovf_q <= 1'b0;
      else if (ien && !wr_acc)  ovf_q <= 1'b1;
   end
   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ifft_reorder_buf.sv
// Directed self-checking bench for ifft_reorder_buf at N=8.
module tb_ifft_reorder_buf;
   localparam int P  = 3;
   localparam int MW = 18;
   localparam int N  = 8;

   logic          iclk = 1'b0, rst = 1'b1, ien = 1'b0, iReady = 1'b0;
   logic [P-1:0]  iaddr = '0;
   logic [MW-1:0] iReal = '0, iImag = '0;
   logic          oValid, olast;
   logic [P-1:0]  oaddr;
   logic [MW-1:0] oReal, oImag;
`ifdef IFFT_REORDER_OVF_EN
   logic          ovf;
`endif

   int checks = 0, failures = 0;
   int rdy_mode = 2;   // 0: ready high, 1: toggle, 2: ready low

   typedef struct {
      logic [P-1:0]  addr;
      logic [MW-1:0] re;
      logic [MW-1:0] im;
      logic          last;
      bit            dc;
   } beat_t;
   beat_t exp_q[$];
   int order [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   ifft_reorder_buf #(.TOTAL_STAGE_P(P), .MULT_WIDTH_P(MW)) dut (
      .iclk(iclk), .rst(rst), .ien(ien), .iaddr(iaddr), .iReal(iReal), .iImag(iImag),
      .oValid(oValid), .iReady(iReady), .oaddr(oaddr), .oReal(oReal), .oImag(oImag),
      .olast(olast)
`ifdef IFFT_REORDER_OVF_EN
      , .ovf(ovf)
`endif
   );

   always #5 iclk = ~iclk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int re_of(input int tag, input int a);
      return tag * 100 + 10 * a;
   endfunction

   task automatic drive(input int a, input int re, input int im);
      ien = 1'b1; iaddr = P'(a); iReal = MW'(re); iImag = MW'(im);
      @(posedge iclk); #1;
   endtask

   task automatic write_frame(input int tag);
      for (int i = 0; i < N; i++) drive(order[i], re_of(tag, order[i]), re_of(tag, order[i]) + 7);
   endtask

   task automatic push_beat(input int a, input int re, input bit dc);
      beat_t b;
      b.addr = P'(a); b.re = MW'(re); b.im = MW'(re + 7); b.last = (a == N - 1); b.dc = dc;
      exp_q.push_back(b);
   endtask

   task automatic push_frame(input int tag);
      for (int a = 0; a < N; a++) push_beat(a, re_of(tag, a), 1'b0);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin @(posedge iclk); n++; end
      check_eq(tag, exp_q.size(), 0);
      exp_q.delete();
      repeat (4) @(negedge iclk);
      check_eq({tag, "_idle"}, oValid, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      @(posedge iclk);
      repeat (2) begin
         @(negedge iclk);
         check_eq("rst_oValid", oValid, 0);
         check_eq("rst_oaddr", oaddr, 0);
         check_eq("rst_oReal", oReal, 0);
         check_eq("rst_oImag", oImag, 0);
         check_eq("rst_olast", olast, 0);
`ifdef IFFT_REORDER_OVF_EN
         check_eq("rst_ovf", ovf, 0);
`endif
      end
      @(posedge iclk); #1;
      rst = 1'b0;
   endtask

   initial begin : ready_drv
      forever begin
         @(posedge iclk); #1;
         case (rdy_mode)
            0:       iReady = 1'b1;
            1:       iReady = ~iReady;
            default: iReady = 1'b0;
         endcase
      end
   end

   // Output monitor: scoreboard compare on each handshake, stability while stalled.
   initial begin : mon
      beat_t b;
      logic hold_v;
      logic [P-1:0] h_addr;
      logic [MW-1:0] h_re, h_im;
      logic h_last;
      hold_v = 1'b0; h_addr = '0; h_re = '0; h_im = '0; h_last = 1'b0;
      forever begin
         @(negedge iclk);
         if (rst) begin
            hold_v = 1'b0;
         end else begin
            if (hold_v) begin
               check_eq("hold_valid", oValid, 1);
               check_eq("hold_addr", oaddr, h_addr);
               check_eq("hold_re", oReal, h_re);
               check_eq("hold_im", oImag, h_im);
               check_eq("hold_last", olast, h_last);
            end
            if (oValid && iReady) begin
               check_eq("beat_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  b = exp_q.pop_front();
                  check_eq("beat_addr", oaddr, b.addr);
                  check_eq("beat_last", olast, b.last);
                  if (!b.dc) begin
                     check_eq("beat_re", oReal, b.re);
                     check_eq("beat_im", oImag, b.im);
                  end
               end
            end
            hold_v = oValid && !iReady;
            h_addr = oaddr; h_re = oReal; h_im = oImag; h_last = olast;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog got=timeout exp=finish checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin : main
      do_reset();

      // scattered write order, full-rate drain, first-beat latency
      rdy_mode = 0;
      @(posedge iclk); #1;
      push_frame(0);
      write_frame(0);
      ien = 1'b0;
      @(negedge iclk); check_eq("t1_lat_k", oValid, 0);
      @(negedge iclk); check_eq("t1_lat_k1", oValid, 0);
      @(negedge iclk); check_eq("t1_lat_k2", oValid, 1);
      check_eq("t1_first_addr", oaddr, 0);
      wait_drain("t1_drain");

      // alternating back-pressure
      rdy_mode = 1;
      push_frame(1);
      write_frame(1);
      ien = 1'b0;
      wait_drain("t2_drain");

      // three back-to-back frames must stream without a gap
      rdy_mode = 0;
      @(posedge iclk); #1;
      push_frame(30); push_frame(31); push_frame(32);
      fork
         begin
            write_frame(30); write_frame(31); write_frame(32);
            ien = 1'b0;
         end
         begin
            int n = 0;
            @(negedge iclk);
            while (!oValid && n < 60) begin @(negedge iclk); n++; end
            for (int i = 0; i < 3 * N; i++) begin
               check_eq("t3_contig", oValid, 1);
               @(negedge iclk);
            end
            check_eq("t3_end_gap", oValid, 0);
         end
      join
      wait_drain("t3_drain");

      // both banks held, third frame must be dropped
      rdy_mode = 2;
      @(posedge iclk); #1;
      push_frame(10); push_frame(11);
      write_frame(10);
      write_frame(11);
`ifdef IFFT_REORDER_OVF_EN
      check_eq("t4_ovf_pre", ovf, 0);
`endif
      write_frame(12);
      ien = 1'b0;
      @(negedge iclk);
`ifdef IFFT_REORDER_OVF_EN
      check_eq("t4_ovf_set", ovf, 1);
`endif
      check_eq("t4_stall_valid", oValid, 1);
      check_eq("t4_stall_addr", oaddr, 0);
      rdy_mode = 0;
      wait_drain("t4_drain");
`ifdef IFFT_REORDER_OVF_EN
      check_eq("t4_ovf_sticky", ovf, 1);
`endif

      // reset mid-drain and mid-frame discards everything
      rdy_mode = 2;
      @(posedge iclk); #1;
      write_frame(20);
      for (int i = 0; i < 5; i++) drive(order[i], re_of(21, order[i]), re_of(21, order[i]) + 7);
      ien = 1'b0;
      @(negedge iclk);
      check_eq("t5_pre_valid", oValid, 1);
      @(posedge iclk); #1;
      do_reset();
      rdy_mode = 0;
      push_frame(22);
      write_frame(22);
      ien = 1'b0;
      wait_drain("t5_drain");

      // duplicate address: last write wins, index 7 never written
      for (int a = 0; a < N; a++)
         push_beat(a, (a == 3) ? 99 : 10 * a, (a == N - 1));
      for (int a = 0; a < N - 1; a++) drive(a, 10 * a, 10 * a + 7);
      drive(3, 99, 106);
      ien = 1'b0;
      @(negedge iclk);
      @(negedge iclk);
      @(negedge iclk); check_eq("t6_complete_8th", oValid, 1);
      wait_drain("t6_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
